// File: rtl/lsu_controller.sv
// lsu_controller: multi-cycle load/store sequencer between the RV32I datapath
// and a req/ack data-memory port. Generates byte-lane enables, positions store
// data into lanes, aligns and sign/zero-extends load data, and aborts a beat
// with bus_err after ACK_TIMEOUT cycles without ack (0 = wait forever).
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned
// accesses are split into two word beats instead of being rejected with
// misalign_err.
module lsu_controller #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  load_store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_out_o,
    output logic        misalign_err_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  ls_q, ls_d;
    logic [1:0]  off_q, off_d;
    logic        split_q, split_d;
    logic [3:0]  be1_q, be1_d;
    logic [31:0] wd1_q, wd1_d;
    logic [31:0] beat0_q, beat0_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    // Lane placement of the incoming request, computed across 8 lanes so the
    // upper half directly gives the second beat of a split access.
    logic [3:0]  mask_in;
    logic [7:0]  be8_in;
    logic [63:0] w64_in;
    logic        split_in;
    logic        launch;
    logic        timeout;
    logic [63:0] rd64;
    logic [31:0] raw;

    function automatic logic [31:0] extend(input logic [2:0] ls, input logic [31:0] r);
        case (ls)
            3'b001:  return {{24{r[7]}}, r[7:0]};
            3'b011:  return {24'h0, r[7:0]};
            3'b010:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {16'h0, r[15:0]};
            default: return r;
        endcase
    endfunction

    // Request decode: size mask, lane enables, store data, split detection.
    always_comb begin
        case (load_store_i)
            3'b001, 3'b011: mask_in = 4'b0001;
            3'b010, 3'b100: mask_in = 4'b0011;
            default:        mask_in = 4'b1111;
        endcase
        be8_in   = {4'b0000, mask_in} << addr_i[1:0];
        w64_in   = {32'h0, wdata_i} << {addr_i[1:0], 3'b000};
        // Lanes spilling past lane 3 are exactly the misaligned cases.
        split_in = |be8_in[7:4];
        timeout  = (ACK_TIMEOUT != 0) && (32'(cnt_q) == ACK_TIMEOUT - 32'd1);
        // Beat1 bytes sit above beat0 bytes; shifting by the offset aligns both.
        rd64     = (state_q == BEAT1) ? {mem_rdata_i, beat0_q} : {32'h0, mem_rdata_i};
        raw      = 32'(rd64 >> {off_q, 3'b000});
    end

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        ls_d       = ls_q;
        off_d      = off_q;
        split_d    = split_q;
        be1_d      = be1_q;
        wd1_d      = wd1_q;
        beat0_d    = beat0_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wd_d       = wd_q;
        rdata_d    = rdata_q;
        mis_d      = mis_q;
        berr_d     = berr_q;
        launch     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    is_store_d = is_store_i;
                    ls_d       = load_store_i;
                    off_d      = addr_i[1:0];
                    split_d    = split_in;
                    be1_d      = be8_in[7:4];
                    wd1_d      = w64_in[63:32];
                    mis_d      = 1'b0;
                    berr_d     = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    launch = 1'b1;
`else
                    if (split_in) begin
                        state_d = RESP;
                        mis_d   = 1'b1;
                    end else begin
                        launch = 1'b1;
                    end
`endif
                end
            end
            BEAT0, BEAT1: begin
                if (mem_ack_i) begin
                    if (state_q == BEAT0 && split_q) begin
                        // Second beat follows back-to-back so a split costs one cycle.
                        state_d = BEAT1;
                        beat0_d = mem_rdata_i;
                        addr_d  = addr_q + 32'd4;
                        be_d    = be1_q;
                        wd_d    = wd1_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = RESP;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        be_d    = 4'b0000;
                        if (!is_store_q) rdata_d = extend(ls_q, raw);
                    end
                end else if (timeout) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    berr_d  = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = BEAT0;
            req_d   = 1'b1;
            we_d    = is_store_i;
            addr_d  = {addr_i[31:2], 2'b00};
            be_d    = be8_in[3:0];
            wd_d    = w64_in[31:0];
            cnt_d   = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            ls_q       <= 3'b000;
            off_q      <= 2'b00;
            split_q    <= 1'b0;
            be1_q      <= 4'b0000;
            wd1_q      <= 32'h0;
            beat0_q    <= 32'h0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'b0000;
            wd_q       <= 32'h0;
            rdata_q    <= 32'h0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            ls_q       <= ls_d;
            off_q      <= off_d;
            split_q    <= split_d;
            be1_q      <= be1_d;
            wd1_q      <= wd1_d;
            beat0_q    <= beat0_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wd_q       <= wd_d;
            rdata_q    <= rdata_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == RESP);
    assign rdata_out_o    = rdata_q;
    assign misalign_err_o = mis_q;
    assign bus_err_o      = berr_q;
    assign mem_req_o      = req_q;
    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_be_o       = be_q;
    assign mem_wdata_o    = wd_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: stimulus pushes expected memory beats
// and completions into queues; a memory responder and a done monitor pop and
// compare whenever the DUT presents a beat or a done pulse.
module tb_lsu_controller;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_store = 1'b0;
    logic [2:0]  ls = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0, mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        busy, done, mis_err, bus_err, mem_req, mem_we;
    logic [31:0] rdata_out, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    lsu_controller #(.ACK_TIMEOUT(16)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .is_store_i(is_store),
        .load_store_i(ls), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .rdata_out_o(rdata_out),
        .misalign_err_o(mis_err), .bus_err_o(bus_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wd; } beat_t;
    typedef struct { logic [31:0] rd; logic mis; logic berr; int cyc; } resp_t;

    beat_t       exp_beats[$];
    resp_t       exp_resp[$];
    logic [31:0] rq[$];
    int          n_cmp = 0, n_err = 0;
    int          wait_states = 0, ws = 0, req_cyc = 0;
    bit          no_ack = 1'b0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: acks after wait_states cycles and checks each beat.
    always @(negedge clk) begin : responder
        beat_t b;
        if (mem_req) req_cyc++;
        if (mem_req && !no_ack) begin
            if (ws >= wait_states) begin
                mem_ack   = 1'b1;
                ws        = 0;
                mem_rdata = (rq.size() != 0) ? rq.pop_front() : 32'h0;
                if (exp_beats.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL beat: unexpected beat at 0x%08h", mem_addr);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_be", {28'h0, mem_be}, {28'h0, b.be});
                    chk("beat_we", {31'h0, mem_we}, {31'h0, b.we});
                    chk("beat_wdata", mem_wdata, b.wd);
                end
            end else begin
                mem_ack = 1'b0;
                ws++;
            end
        end else begin
            mem_ack = 1'b0;
            ws      = 0;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin : done_mon
        resp_t r;
        if (done) begin
            if (exp_resp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL done: unexpected done at cycle %0d", cyc);
            end else begin
                r = exp_resp.pop_front();
                chk("rdata_out", rdata_out, r.rd);
                chk("misalign_err", {31'h0, mis_err}, {31'h0, r.mis});
                chk("bus_err", {31'h0, bus_err}, {31'h0, r.berr});
                chk("done_cycle", cyc, r.cyc);
                chk("busy_on_done", {31'h0, busy}, 32'h1);
                chk("req_low_on_done", {31'h0, mem_req}, 32'h0);
            end
        end
    end

    task automatic beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                        input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wd = wd;
        exp_beats.push_back(b);
    endtask

    task automatic issue(input logic st, input logic [2:0] l, input logic [31:0] a,
                         input logic [31:0] w, input int lat, input logic [31:0] rd,
                         input logic mis, input logic berr);
        resp_t r;
        @(negedge clk);
        r.rd = rd; r.mis = mis; r.berr = berr; r.cyc = cyc + lat;
        exp_resp.push_back(r);
        start = 1'b1; is_store = st; ls = l; addr = a; wdata = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_cmp++; n_err++;
        $display("FAIL %s: still busy after 60 cycles", nm);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_be", {28'h0, mem_be}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_errs", {30'h0, mis_err, bus_err}, 32'h0);
        reset = 1'b0;

        // lw 0x100, zero wait states
        beat(32'h100, 4'b1111, 1'b0, 32'h0); rq.push_back(32'h8000_00F0);
        issue(1'b0, 3'b000, 32'h100, 32'h0, 2, 32'h8000_00F0, 1'b0, 1'b0);
        wait_idle("lw");
        // lb / lbu from lane 3
        beat(32'h200, 4'b1000, 1'b0, 32'h0); rq.push_back(32'h8000_0000);
        issue(1'b0, 3'b001, 32'h203, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 1'b0);
        wait_idle("lb");
        beat(32'h200, 4'b1000, 1'b0, 32'h0); rq.push_back(32'h8000_0000);
        issue(1'b0, 3'b011, 32'h203, 32'h0, 2, 32'h0000_0080, 1'b0, 1'b0);
        wait_idle("lbu");
        last_rd = 32'h0000_0080;
        // sh keeps rdata_out
        beat(32'h300, 4'b1100, 1'b1, 32'hABCD_0000);
        issue(1'b1, 3'b010, 32'h302, 32'h1234_ABCD, 2, last_rd, 1'b0, 1'b0);
        wait_idle("sh");
        // lh / lhu from upper half
        beat(32'h100, 4'b1100, 1'b0, 32'h0); rq.push_back(32'h8001_1234);
        issue(1'b0, 3'b010, 32'h102, 32'h0, 2, 32'hFFFF_8001, 1'b0, 1'b0);
        wait_idle("lh");
        beat(32'h100, 4'b1100, 1'b0, 32'h0); rq.push_back(32'hF00D_5678);
        issue(1'b0, 3'b100, 32'h102, 32'h0, 2, 32'h0000_F00D, 1'b0, 1'b0);
        wait_idle("lhu");
        last_rd = 32'h0000_F00D;

        // misaligned lw 0x401 and sh 0x303
`ifdef LSU_MISALIGN_SPLIT_EN
        beat(32'h400, 4'b1110, 1'b0, 32'h0); beat(32'h404, 4'b0001, 1'b0, 32'h0);
        rq.push_back(32'h3322_11AA); rq.push_back(32'hBBCC_DD44);
        issue(1'b0, 3'b000, 32'h401, 32'h0, 3, 32'h4433_2211, 1'b0, 1'b0);
        wait_idle("lw_split");
        last_rd = 32'h4433_2211;
        beat(32'h300, 4'b1000, 1'b1, 32'hEF00_0000); beat(32'h304, 4'b0001, 1'b1, 32'h0000_00BE);
        issue(1'b1, 3'b010, 32'h303, 32'h0000_BEEF, 3, last_rd, 1'b0, 1'b0);
        wait_idle("sh_split");
`else
        issue(1'b0, 3'b000, 32'h401, 32'h0, 1, last_rd, 1'b1, 1'b0);
        wait_idle("lw_mis");
        issue(1'b1, 3'b010, 32'h303, 32'h0000_BEEF, 1, last_rd, 1'b1, 1'b0);
        wait_idle("sh_mis");
`endif

        // lh 0x501 with 3 wait states; a stray start while busy is ignored
        wait_states = 3;
        beat(32'h500, 4'b0110, 1'b0, 32'h0); rq.push_back(32'h00AB_CD00);
        issue(1'b0, 3'b010, 32'h501, 32'h0, 5, 32'hFFFF_ABCD, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; addr = 32'h123; ls = 3'b000;
        @(negedge clk);
        start = 1'b0;
        wait_idle("lh_wait");
        wait_states = 0;

        // ack timeout
        no_ack = 1'b1; req_cyc = 0;
        issue(1'b0, 3'b000, 32'h600, 32'h0, 17, 32'h0, 1'b0, 1'b1);
        wait_idle("timeout");
        chk("timeout_req_cycles", req_cyc, 32'd16);
        no_ack = 1'b0;

        // lb lane 1
        beat(32'h000, 4'b0010, 1'b0, 32'h0); rq.push_back(32'h0000_7F00);
        issue(1'b0, 3'b001, 32'h001, 32'h0, 2, 32'h0000_007F, 1'b0, 1'b0);
        wait_idle("lb1");

        // reset while waiting in BEAT0: no done afterwards
        no_ack = 1'b1;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; ls = 3'b000; addr = 32'h700;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'h0, mem_req}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_done", {31'h0, done}, 32'h0);
        chk("midrst_rdata", rdata_out, 32'h0);
        reset = 1'b0; no_ack = 1'b0;
        repeat (5) @(negedge clk);

        // sb lane 1 keeps rdata_out (0 after reset)
        beat(32'h000, 4'b0010, 1'b1, 32'h0000_A500);
        issue(1'b1, 3'b001, 32'h001, 32'h0000_00A5, 2, 32'h0, 1'b0, 1'b0);
        wait_idle("sb");

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", exp_resp.size(), 32'd0);
        chk("beat_queue_empty", exp_beats.size(), 32'd0);
        chk("rdata_queue_empty", rq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
